// File: rtl/alu_pkg.sv
// Shared encodings for the ALU decoder and the mul/div sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_MULH = 4'b1011;
  localparam logic [3:0] ALU_DIV  = 4'b1100;
  localparam logic [3:0] ALU_DIVU = 4'b1101;
  localparam logic [3:0] ALU_REM  = 4'b1110;
  localparam logic [3:0] ALU_REMU = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational alu_op/funct3/funct7 decode with illegal-encoding flag.
module alu_decode_comb
  import alu_pkg::*;
#(
  parameter int EN_EXT = 1,
  parameter int EN_M   = 1,
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              op_5,
  input  logic              funct7_5,
  input  logic              funct7_0,
  output logic [CTRL_W-1:0] alu_control,
  output logic              is_m,
  output logic              illegal
);

  logic [3:0] code;

  always_comb begin
    code    = ALU_ADD;
    is_m    = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      ALU_OP_ADD: code = ALU_ADD;
      ALU_OP_SUB: code = ALU_SUB;
      ALU_OP_FUNCT: begin
        if (op_5 && funct7_0) begin
          if (EN_M != 0) begin
            is_m = 1'b1;
            case (funct3)
              3'b000:  code = ALU_MUL;
              3'b001:  code = ALU_MULH;
              3'b100:  code = ALU_DIV;
              3'b101:  code = ALU_DIVU;
              3'b110:  code = ALU_REM;
              3'b111:  code = ALU_REMU;
              default: begin
                is_m    = 1'b0;
                illegal = 1'b1;
              end
            endcase
          end else begin
            illegal = 1'b1;
          end
        end else begin
          case (funct3)
            3'b000: code = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: code = ALU_SLL;
            3'b010: code = ALU_SLT;
            3'b011: begin
              if (EN_EXT != 0) code = ALU_SLTU;
              else illegal = 1'b1;
            end
            3'b100: code = ALU_XOR;
            3'b101: begin
              if (!funct7_5) code = ALU_SRL;
              else if (EN_EXT != 0) code = ALU_SRA;
              else illegal = 1'b1;
            end
            3'b110: code = ALU_OR;
            default: code = ALU_AND;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings always fall back to ADD, whatever was picked above.
    if (illegal) code = ALU_ADD;
    alu_control = code[CTRL_W-1:0];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU decode with start/done handshake and mul/div sequencing.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int EN_EXT     = 1,
  parameter int EN_M       = 1,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              op_5,
  input  logic              funct7_5,
  input  logic              funct7_0,
  input  logic              md_done,
  output logic [CTRL_W-1:0] alu_control,
  output logic              md_start,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              md_timeout
);

  localparam logic [15:0] TMO_LAST = 16'(MD_TIMEOUT - 1);

  state_e            state;
  logic [15:0]       cnt;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_m;
  logic              dec_illegal;

  alu_decode_comb #(
    .EN_EXT (EN_EXT),
    .EN_M   (EN_M),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_5        (op_5),
    .funct7_5    (funct7_5),
    .funct7_0    (funct7_0),
    .alu_control (dec_ctrl),
    .is_m        (dec_m),
    .illegal     (dec_illegal)
  );

  // Outputs are registered alongside the state transition, so each flag is
  // valid in the same cycle the state it belongs to is entered. S_EXEC is the
  // execute cycle of a single-cycle op ahead of the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      alu_control <= '0;
      md_start    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      md_timeout  <= 1'b0;
      cnt         <= '0;
    end else begin
      md_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            alu_control <= dec_ctrl;
            illegal     <= dec_illegal;
            md_timeout  <= 1'b0;
            busy        <= 1'b1;
            if (dec_m) begin
              state    <= S_ISSUE;
              md_start <= 1'b1;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (md_done) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (cnt == TMO_LAST) begin
            md_timeout <= 1'b1;
            state      <= S_DONE;
            done       <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
